if_fetch_stage: RTL



---
 rtl/if_fetch_stage.sv | 104 ++++++++++
 1 files changed

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: PC, debug-loadable instruction memory, stall/redirect/step control, HALT detection.
// Optional fetched-instruction counter enabled by defining IF_FETCH_COUNT_EN.
module if_fetch_stage #(
  parameter int               MSB       = 32,
  parameter int               ADDR_W    = 8,
  parameter logic [MSB-1:0]   HALT_WORD = 32'hFFFFFFFF
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [MSB-1:0]    i_wr_data,
  input  logic              i_run,
  input  logic              i_en,
  input  logic              i_stall,
  input  logic              i_pc_src,
  input  logic [MSB-1:0]    i_target_pc,
  output logic [MSB-1:0]    IF_next_pc,
  output logic [MSB-1:0]    IF_inst,
  output logic [MSB-1:0]    o_pc,
  output logic              o_halted,
  output logic [31:0]       o_fetch_cnt
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] RUN    = 2'd1;
  localparam logic [1:0] HALTED = 2'd2;

  logic [1:0]     state_q, state_d;
  logic [MSB-1:0] pc_q, pc_d;
  logic [MSB-1:0] mem_q [0:(1<<ADDR_W)-1];
  logic [MSB-1:0] fetch_word;

  // Memory is deliberately not reset so a loaded program survives i_rst.
  always_ff @(posedge i_clk) begin
    if (i_wr_en && state_q == IDLE) begin
      mem_q[i_wr_addr] <= i_wr_data;
    end
  end

  assign fetch_word = mem_q[pc_q[ADDR_W+1:2]];
  assign IF_inst    = (state_q == RUN) ? fetch_word : '0;
  assign IF_next_pc = pc_q + MSB'(4);
  assign o_pc       = pc_q;
  assign o_halted   = (state_q == HALTED);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    case (state_q)
      IDLE: begin
        if (i_run) state_d = RUN;
      end
      RUN: begin
        if (i_en) begin
          if (i_pc_src) begin
            pc_d = i_target_pc & ~MSB'(3);
          end else if (i_stall) begin
            pc_d = pc_q;
          end else if (fetch_word == HALT_WORD) begin
            state_d = HALTED;
          end else begin
            pc_d = pc_q + MSB'(4);
          end
        end
      end
      default: begin
        state_d = state_q;
        pc_d    = pc_q;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      pc_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

`ifdef IF_FETCH_COUNT_EN
  logic        advance;
  logic [31:0] cnt_q;

  // Redirect, HALT capture and plain increment all count; stall and i_en=0 do not.
  assign advance = (state_q == RUN) && i_en && (i_pc_src || !i_stall);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt_q <= '0;
    end else if (advance) begin
      cnt_q <= cnt_q + 32'd1;
    end
  end

  assign o_fetch_cnt = cnt_q;
`else
  assign o_fetch_cnt = '0;
`endif

endmodule
